// File: rtl/ex_hazard_controller.sv
// EX-stage hazard controller: operand forwarding selects, load-use stalls,
// branch flushes and a sequencer that holds E for multi-cycle ALU ops.
module ex_hazard_controller #(
  parameter int unsigned MC_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic [4:0]  rs1_e,
  input  logic [4:0]  rs2_e,
  input  logic [4:0]  rd_e,
  input  logic [1:0]  result_src_e,
  input  logic        pc_src_e,
  input  logic        mc_op_e,
  input  logic [4:0]  rd_m,
  input  logic        regwrite_m,
  input  logic [4:0]  rd_w,
  input  logic        regwrite_w,
  output logic [1:0]  forward_operand_a_e,
  output logic [1:0]  forward_operand_b_e,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_e,
  output logic        flush_d,
  output logic        flush_e,
  output logic        flush_m,
  output logic        mc_capture,
  output logic        mc_done,
  output logic [31:0] stall_cycles
);

  localparam int CNT_W = $clog2(MC_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        stall_cycles_q, stall_cycles_d;
  logic               lw_stall;
  logic               mc_stall;

  // M has priority over W because it holds the younger result.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rdm,
    input logic       wem,
    input logic [4:0] rdw,
    input logic       wew
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (wem && (rdm != 5'd0) && (rdm == rs))      sel = 2'b10;
    else if (wew && (rdw != 5'd0) && (rdw == rs)) sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (mc_op_e) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(MC_CYCLES - 1);
        end
      end
      BUSY: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else             state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lw_stall = (result_src_e == 2'b01) && (rd_e != 5'd0) &&
               ((rd_e == rs1_d) || (rd_e == rs2_d)) && !pc_src_e;
    mc_stall = ((state_q == IDLE) && mc_op_e) || (state_q == BUSY);

    forward_operand_a_e = 2'b00;
    forward_operand_b_e = 2'b00;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    flush_d    = 1'b1;
    flush_e    = 1'b1;
    flush_m    = 1'b1;
    mc_capture = 1'b0;
    mc_done    = 1'b0;

    // Reset forces bubbles everywhere and suppresses all stall/handshake outputs.
    if (!reset) begin
      forward_operand_a_e = fwd_sel(rs1_e, rd_m, regwrite_m, rd_w, regwrite_w);
      forward_operand_b_e = fwd_sel(rs2_e, rd_m, regwrite_m, rd_w, regwrite_w);
      stall_f    = lw_stall || mc_stall;
      stall_d    = lw_stall || mc_stall;
      stall_e    = mc_stall;
      flush_m    = mc_stall;
      flush_e    = (lw_stall || pc_src_e) && !mc_stall;
      flush_d    = pc_src_e && !mc_stall;
      mc_capture = (state_q == IDLE) && mc_op_e;
      mc_done    = (state_q == DONE);
    end

    stall_cycles_d = stall_f ? stall_cycles_q + 32'd1 : stall_cycles_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      stall_cycles_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule
